// File: rtl/cpu_ctrl_pkg.sv
// Shared control definitions for the hardwired sequencer and the ALU:
// state encoding, opcode values, IR field positions and opcode classifiers.
package cpu_ctrl_pkg;

  localparam int OPC_BITS  = 5;
  localparam int REG_IDX_W = 4;

  typedef logic [OPC_BITS-1:0]  opc_t;
  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_T0,
    ST_T1,
    ST_T2,
    ST_T3,
    ST_T4,
    ST_T5,
    ST_T6,
    ST_ILLEGAL
  } state_t;

  // ALU function codes; the same values drive the ALU select directly.
  localparam opc_t OP_ADD = 5'b00011;
  localparam opc_t OP_SUB = 5'b00100;
  localparam opc_t OP_AND = 5'b00101;
  localparam opc_t OP_OR  = 5'b00110;
  localparam opc_t OP_SHR = 5'b00111;
  localparam opc_t OP_SHL = 5'b01000;
  localparam opc_t OP_ROR = 5'b01001;
  localparam opc_t OP_ROL = 5'b01010;
  localparam opc_t OP_MUL = 5'b01111;
  localparam opc_t OP_DIV = 5'b10000;

  // IR field bit positions.
  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 27;
  localparam int RA_MSB  = 26;
  localparam int RA_LSB  = 23;
  localparam int RB_MSB  = 22;
  localparam int RB_LSB  = 19;
  localparam int RC_MSB  = 18;
  localparam int RC_LSB  = 15;

  function automatic logic is_legal_op(input opc_t op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR,
      OP_SHL, OP_ROR, OP_ROL, OP_MUL, OP_DIV: is_legal_op = 1'b1;
      default:                                is_legal_op = 1'b0;
    endcase
  endfunction

  // MUL/DIV produce a 64-bit result that needs the extra HI writeback step.
  function automatic logic is_hilo_op(input opc_t op);
    is_hilo_op = (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/reg_sel_decoder.sv
// Register index to one-hot enable decoder with an out-of-range flag.
// The flag reflects only the index, independent of the enable, so it can be
// used to qualify the enable without forming a combinational loop.
module reg_sel_decoder
  import cpu_ctrl_pkg::*;
#(
  parameter int NUM_REGS = 16
) (
  input  logic [REG_IDX_W-1:0] idx,
  input  logic                 en,
  output logic [NUM_REGS-1:0]  onehot,
  output logic                 out_of_range
);

  localparam int               NUM_REGS_I = NUM_REGS;
  localparam logic [REG_IDX_W:0] NUM_REGS_L = NUM_REGS_I[REG_IDX_W:0];

  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_bit
      assign onehot[gi] = en && (idx == REG_IDX_W'(gi));
    end
  endgenerate

  assign out_of_range = ({1'b0, idx} >= NUM_REGS_L);

endmodule

// File: rtl/alu_op_sequencer.sv
// Hardwired Moore control sequencer: fetch (T0-T2) and register-register
// ALU execute (T3-T5, plus T6 for the HI writeback of MUL/DIV).
// Outputs decode only from the registered state and the fields latched at
// the T2->T3 edge, so ir_in may change freely once the IR has loaded.
module alu_op_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int DATA_W   = 32,
  parameter int OPC_W    = 5
) (
  input  logic                Clock,
  input  logic                Clear,
  input  logic                run,
  input  logic [DATA_W-1:0]   ir_in,
  input  logic                mem_ready,
  output logic                PCout,
  output logic                PCin,
  output logic                IncPC,
  output logic                MARin,
  output logic                Read,
  output logic                MDRin,
  output logic                MDRout,
  output logic                IRin,
  output logic                Yin,
  output logic                ZLowIn,
  output logic                ZHighIn,
  output logic                Zlowout,
  output logic                ZHighout,
  output logic                HIin,
  output logic                LOin,
  output logic [OPC_W-1:0]    alu_op,
  output logic [NUM_REGS-1:0] reg_in,
  output logic [NUM_REGS-1:0] reg_out,
  output logic                busy,
  output logic                done,
  output logic                illegal
);

  localparam int                 NUM_REGS_I = NUM_REGS;
  localparam logic [REG_IDX_W:0] NUM_REGS_L = NUM_REGS_I[REG_IDX_W:0];

  state_t   state_q, state_d;
  opc_t     opc_q, opc_d;
  reg_idx_t ra_q, ra_d, rb_q, rb_d, rc_q, rc_d;
  logic     t1_wait_q, t1_wait_d;   // set on every T1 cycle after the first

  logic     reg_in_en, reg_out_en;
  reg_idx_t out_idx;
  logic     ra_oor, out_oor, rc_oor;
  logic     hilo, decode_bad;
  logic     ir_unused;

  // Only the opcode and register fields are consumed from the IR.
  assign ir_unused = ^ir_in;

  assign hilo    = is_hilo_op(opc_q);
  // T3 drives rb onto the bus, T4 drives rc.
  assign out_idx = (state_q == ST_T4) ? rc_q : rb_q;
  assign rc_oor  = ({1'b0, rc_q} >= NUM_REGS_L);
  // Evaluated in T3, where the reg_out decoder is looking at rb.
  assign decode_bad = !is_legal_op(opc_q) || ra_oor || out_oor || rc_oor;

  reg_sel_decoder #(.NUM_REGS(NUM_REGS)) u_reg_in_dec (
    .idx          (ra_q),
    .en           (reg_in_en),
    .onehot       (reg_in),
    .out_of_range (ra_oor)
  );

  reg_sel_decoder #(.NUM_REGS(NUM_REGS)) u_reg_out_dec (
    .idx          (out_idx),
    .en           (reg_out_en),
    .onehot       (reg_out),
    .out_of_range (out_oor)
  );

  // State and latched IR fields; Clear wipes everything immediately.
  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      state_q   <= ST_IDLE;
      opc_q     <= '0;
      ra_q      <= '0;
      rb_q      <= '0;
      rc_q      <= '0;
      t1_wait_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      opc_q     <= opc_d;
      ra_q      <= ra_d;
      rb_q      <= rb_d;
      rc_q      <= rc_d;
      t1_wait_q <= t1_wait_d;
    end
  end

  // Next-state sequencing and field capture at the T2->T3 edge.
  always_comb begin
    state_d   = state_q;
    opc_d     = opc_q;
    ra_d      = ra_q;
    rb_d      = rb_q;
    rc_d      = rc_q;
    t1_wait_d = 1'b0;
    case (state_q)
      ST_IDLE: if (run) state_d = ST_T0;
      ST_T0:   state_d = ST_T1;
      ST_T1: begin
        if (mem_ready) state_d = ST_T2;
        else           t1_wait_d = 1'b1;
      end
      ST_T2: begin
        state_d = ST_T3;
        opc_d   = ir_in[OPC_MSB:OPC_LSB];
        ra_d    = ir_in[RA_MSB:RA_LSB];
        rb_d    = ir_in[RB_MSB:RB_LSB];
        rc_d    = ir_in[RC_MSB:RC_LSB];
      end
      ST_T3:   state_d = decode_bad ? ST_ILLEGAL : ST_T4;
      ST_T4:   state_d = ST_T5;
      ST_T5: begin
        if (hilo)     state_d = ST_T6;
        else if (run) state_d = ST_T0;
        else          state_d = ST_IDLE;
      end
      ST_T6:      state_d = run ? ST_T0 : ST_IDLE;
      ST_ILLEGAL: state_d = ST_ILLEGAL;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Moore output decode from the registered state and latched fields.
  always_comb begin
    PCout      = 1'b0;
    PCin       = 1'b0;
    IncPC      = 1'b0;
    MARin      = 1'b0;
    Read       = 1'b0;
    MDRin      = 1'b0;
    MDRout     = 1'b0;
    IRin       = 1'b0;
    Yin        = 1'b0;
    ZLowIn     = 1'b0;
    ZHighIn    = 1'b0;
    Zlowout    = 1'b0;
    ZHighout   = 1'b0;
    HIin       = 1'b0;
    LOin       = 1'b0;
    alu_op     = '0;
    reg_in_en  = 1'b0;
    reg_out_en = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    illegal    = 1'b0;
    case (state_q)
      ST_T0: begin
        busy   = 1'b1;
        PCout  = 1'b1;
        MARin  = 1'b1;
        IncPC  = 1'b1;
        ZLowIn = 1'b1;
      end
      ST_T1: begin
        busy    = 1'b1;
        Zlowout = 1'b1;
        PCin    = !t1_wait_q;
        Read    = 1'b1;
        MDRin   = 1'b1;
      end
      ST_T2: begin
        busy   = 1'b1;
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      ST_T3: begin
        busy       = 1'b1;
        reg_out_en = !decode_bad;
        Yin        = !decode_bad;
      end
      ST_T4: begin
        busy       = 1'b1;
        reg_out_en = 1'b1;
        ZLowIn     = 1'b1;
        ZHighIn    = hilo;
        alu_op     = OPC_W'(opc_q);
      end
      ST_T5: begin
        busy      = 1'b1;
        Zlowout   = 1'b1;
        LOin      = hilo;
        reg_in_en = !hilo;
        done      = !hilo;
      end
      ST_T6: begin
        busy     = 1'b1;
        ZHighout = 1'b1;
        HIin     = 1'b1;
        done     = 1'b1;
      end
      ST_ILLEGAL: illegal = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
module tb_alu_op_sequencer;

  typedef struct packed {
    logic        pc_out;
    logic        pc_in;
    logic        inc_pc;
    logic        mar_in;
    logic        read;
    logic        mdr_in;
    logic        mdr_out;
    logic        ir_load;
    logic        y_in;
    logic        zlow_in;
    logic        zhigh_in;
    logic        zlow_out;
    logic        zhigh_out;
    logic        hi_in;
    logic        lo_in;
    logic [4:0]  alu_op;
    logic [15:0] reg_in;
    logic [15:0] reg_out;
    logic        busy;
    logic        done;
    logic        illegal;
  } outs_t;

  typedef struct {
    logic [31:0] ir;
    int          waits;
    bit          sel8;
    int          cycles;
    logic [15:0] ro_t3;
    logic [15:0] ro_t4;
    logic [15:0] ri_last;
    logic [4:0]  alu;
    bit          ill;
  } vec_t;

  logic        clk = 1'b0;
  logic        Clear;
  logic        run;
  logic        mem_ready;
  logic [31:0] ir_in;

  int checks   = 0;
  int failures = 0;

  outs_t exp_q[$];
  bit    mr_q[$];
  outs_t obs_q[$];

  // 16-register instance outputs
  logic a_PCout, a_PCin, a_IncPC, a_MARin, a_Read, a_MDRin, a_MDRout, a_IRin;
  logic a_Yin, a_ZLowIn, a_ZHighIn, a_Zlowout, a_ZHighout, a_HIin, a_LOin;
  logic [4:0]  a_alu_op;
  logic [15:0] a_reg_in, a_reg_out;
  logic a_busy, a_done, a_illegal;

  // 8-register instance outputs
  logic b_PCout, b_PCin, b_IncPC, b_MARin, b_Read, b_MDRin, b_MDRout, b_IRin;
  logic b_Yin, b_ZLowIn, b_ZHighIn, b_Zlowout, b_ZHighout, b_HIin, b_LOin;
  logic [4:0] b_alu_op;
  logic [7:0] b_reg_in, b_reg_out;
  logic b_busy, b_done, b_illegal;

  outs_t o16, o8;

  assign o16 = {a_PCout, a_PCin, a_IncPC, a_MARin, a_Read, a_MDRin, a_MDRout, a_IRin,
                a_Yin, a_ZLowIn, a_ZHighIn, a_Zlowout, a_ZHighout, a_HIin, a_LOin,
                a_alu_op, a_reg_in, a_reg_out, a_busy, a_done, a_illegal};
  assign o8  = {b_PCout, b_PCin, b_IncPC, b_MARin, b_Read, b_MDRin, b_MDRout, b_IRin,
                b_Yin, b_ZLowIn, b_ZHighIn, b_Zlowout, b_ZHighout, b_HIin, b_LOin,
                b_alu_op, 8'h00, b_reg_in, 8'h00, b_reg_out, b_busy, b_done, b_illegal};

  always #5 clk = ~clk;

  alu_op_sequencer #(.NUM_REGS(16), .DATA_W(32), .OPC_W(5)) dut (
    .Clock(clk), .Clear(Clear), .run(run), .ir_in(ir_in), .mem_ready(mem_ready),
    .PCout(a_PCout), .PCin(a_PCin), .IncPC(a_IncPC), .MARin(a_MARin),
    .Read(a_Read), .MDRin(a_MDRin), .MDRout(a_MDRout), .IRin(a_IRin),
    .Yin(a_Yin), .ZLowIn(a_ZLowIn), .ZHighIn(a_ZHighIn), .Zlowout(a_Zlowout),
    .ZHighout(a_ZHighout), .HIin(a_HIin), .LOin(a_LOin), .alu_op(a_alu_op),
    .reg_in(a_reg_in), .reg_out(a_reg_out), .busy(a_busy), .done(a_done),
    .illegal(a_illegal)
  );

  alu_op_sequencer #(.NUM_REGS(8), .DATA_W(32), .OPC_W(5)) dut8 (
    .Clock(clk), .Clear(Clear), .run(run), .ir_in(ir_in), .mem_ready(mem_ready),
    .PCout(b_PCout), .PCin(b_PCin), .IncPC(b_IncPC), .MARin(b_MARin),
    .Read(b_Read), .MDRin(b_MDRin), .MDRout(b_MDRout), .IRin(b_IRin),
    .Yin(b_Yin), .ZLowIn(b_ZLowIn), .ZHighIn(b_ZHighIn), .Zlowout(b_Zlowout),
    .ZHighout(b_ZHighout), .HIin(b_HIin), .LOin(b_LOin), .alu_op(b_alu_op),
    .reg_in(b_reg_in), .reg_out(b_reg_out), .busy(b_busy), .done(b_done),
    .illegal(b_illegal)
  );

  function automatic logic [31:0] mk_ir(input int opc, input int ra, input int rb, input int rc);
    mk_ir = (32'(opc) << 27) | (32'(ra) << 23) | (32'(rb) << 19) | (32'(rc) << 15);
  endfunction

  task automatic check_outs(input string name, input int nregs, input outs_t act, input outs_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s regs=%0d act=%h exp=%h", name, nregs, act, exp);
    end
  endtask

  task automatic check_val(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic push(input outs_t s, input bit mr);
    exp_q.push_back(s);
    mr_q.push_back(mr);
  endtask

  // Reference: the list of per-cycle strobe sets one instruction must produce,
  // from T0 to its done cycle (or to the ILLEGAL state), plus the mem_ready
  // value the bench drives in each of those cycles.
  task automatic build(input logic [31:0] ir, input int waits, input int nregs);
    outs_t s;
    int    opc, ra, rb, rc;
    bit    legal, hilo;
    opc   = int'(ir[31:27]);
    ra    = int'(ir[26:23]);
    rb    = int'(ir[22:19]);
    rc    = int'(ir[18:15]);
    legal = (opc >= 3 && opc <= 10) || opc == 15 || opc == 16;
    hilo  = (opc == 15) || (opc == 16);
    exp_q.delete();
    mr_q.delete();
    s = '0; s.pc_out = 1; s.mar_in = 1; s.inc_pc = 1; s.zlow_in = 1; s.busy = 1;
    push(s, 1'($urandom_range(0, 1)));
    for (int w = 0; w <= waits; w++) begin
      s = '0; s.zlow_out = 1; s.read = 1; s.mdr_in = 1; s.busy = 1; s.pc_in = (w == 0);
      push(s, w == waits);
    end
    s = '0; s.mdr_out = 1; s.ir_load = 1; s.busy = 1;
    push(s, 1'($urandom_range(0, 1)));
    if (!legal || ra >= nregs || rb >= nregs || rc >= nregs) begin
      s = '0; s.busy = 1;
      push(s, 1'($urandom_range(0, 1)));
      s = '0; s.illegal = 1;
      push(s, 1'($urandom_range(0, 1)));
      return;
    end
    s = '0; s.reg_out = 16'(1) << rb; s.y_in = 1; s.busy = 1;
    push(s, 1'($urandom_range(0, 1)));
    s = '0; s.reg_out = 16'(1) << rc; s.zlow_in = 1; s.zhigh_in = hilo;
    s.alu_op = 5'(opc); s.busy = 1;
    push(s, 1'($urandom_range(0, 1)));
    if (hilo) begin
      s = '0; s.zlow_out = 1; s.lo_in = 1; s.busy = 1;
      push(s, 1'($urandom_range(0, 1)));
      s = '0; s.zhigh_out = 1; s.hi_in = 1; s.done = 1; s.busy = 1;
      push(s, 1'($urandom_range(0, 1)));
    end else begin
      s = '0; s.zlow_out = 1; s.reg_in = 16'(1) << ra; s.done = 1; s.busy = 1;
      push(s, 1'($urandom_range(0, 1)));
    end
  endtask

  // Entry: DUT is in IDLE with run=1, or in a done cycle with run=1, so the
  // next rising edge enters T0.
  task automatic run_instr(input logic [31:0] ir, input int waits, input bit sel8,
                           input int drop_idx, input bit next_run, input int abort_idx);
    int    nregs;
    outs_t cur;
    outs_t zero;
    zero  = '0;
    nregs = sel8 ? 8 : 16;
    build(ir, waits, nregs);
    obs_q.delete();
    ir_in = ir;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      cur = sel8 ? o8 : o16;
      obs_q.push_back(cur);
      check_outs($sformatf("cycle%0d_ir%08h", i, ir), nregs, cur, exp_q[i]);
      if (i == abort_idx) begin
        Clear = 1'b1;
        #1;
        check_outs("clear_same_cycle", 16, o16, zero);
        check_val("clear_busy", int'(o16.busy), 0);
        @(negedge clk);
        check_outs("clear_held_idle", 16, o16, zero);
        Clear = 1'b0;
        run   = 1'b1;
        $display("instr ir=%08h aborted by Clear at cycle %0d", ir, i);
        return;
      end
      mem_ready = mr_q[i];
      if (i >= 3 + waits) ir_in = $urandom;   // fields are already latched
      run = (i < drop_idx);
      if (i == exp_q.size() - 1) run = next_run;
    end
    $display("instr ir=%08h regs=%0d waits=%0d cycles=%0d illegal=%0d",
             ir, nregs, waits, exp_q.size(), exp_q[exp_q.size()-1].illegal);
    if (!next_run && !exp_q[exp_q.size()-1].illegal) begin
      @(negedge clk);
      cur = sel8 ? o8 : o16;
      check_outs("idle_after_done", nregs, cur, zero);
      run = 1'b1;
    end
  endtask

  task automatic do_clear();
    @(negedge clk);
    Clear = 1'b1;
    run   = 1'b0;
    @(negedge clk);
    Clear = 1'b0;
    run   = 1'b1;
  endtask

  task automatic check_sticky(input bit sel8, input int n);
    outs_t e;
    e = '0;
    e.illegal = 1'b1;
    for (int k = 0; k < n; k++) begin
      run       = 1'b1;
      mem_ready = 1'($urandom_range(0, 1));
      ir_in     = $urandom;
      @(negedge clk);
      check_outs($sformatf("illegal_sticky%0d", k), sel8 ? 8 : 16, sel8 ? o8 : o16, e);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t  tbl[7];
    outs_t zero;
    int    cyc, w, opc, nregs, ra, rb, rc;
    int    legal_ops[10];
    bit    sel8;
    logic [31:0] ir;

    legal_ops = '{3, 4, 5, 6, 7, 8, 9, 10, 15, 16};
    zero = '0;
    //           ir            w  s8 cyc  ro_t3    ro_t4    ri_last  alu   ill
    tbl[0] = '{32'h1A920000, 0, 0, 6, 16'h0004, 16'h0010, 16'h0020, 5'd3,  0};
    tbl[1] = '{32'h781B0000, 0, 0, 7, 16'h0008, 16'h0040, 16'h0000, 5'd15, 0};
    tbl[2] = '{32'h1A920000, 3, 0, 9, 16'h0004, 16'h0010, 16'h0020, 5'd3,  0};
    tbl[3] = '{32'hF8000000, 0, 0, 5, 16'h0000, 16'h0000, 16'h0000, 5'd0,  1};
    tbl[4] = '{32'h18948000, 0, 1, 5, 16'h0000, 16'h0000, 16'h0000, 5'd0,  1};
    tbl[5] = '{32'h83880000, 0, 1, 7, 16'h0002, 16'h0001, 16'h0000, 5'd16, 0};
    tbl[6] = '{32'h47F80000, 1, 0, 7, 16'h8000, 16'h0001, 16'h8000, 5'd8,  0};

    Clear     = 1'b1;
    run       = 1'b0;
    mem_ready = 1'b1;
    ir_in     = '0;
    @(negedge clk);
    check_outs("reset_state", 16, o16, zero);
    check_outs("reset_state", 8, o8, zero);
    Clear = 1'b0;
    @(negedge clk);
    check_outs("idle_run_low", 16, o16, zero);
    run = 1'b1;

    // Directed vectors
    for (int t = 0; t < 7; t++) begin
      do_clear();
      run_instr(tbl[t].ir, tbl[t].waits, tbl[t].sel8, 99, 1'b1, -1);
      w   = tbl[t].waits;
      cyc = 0;
      for (int i = 0; i < obs_q.size(); i++)
        if ((obs_q[i].done || obs_q[i].illegal) && cyc == 0) cyc = i + 1;
      check_val($sformatf("vec%0d_cycles", t), cyc, tbl[t].cycles);
      check_val($sformatf("vec%0d_reg_out_t3", t), int'(obs_q[3+w].reg_out), int'(tbl[t].ro_t3));
      check_val($sformatf("vec%0d_reg_out_t4", t), int'(obs_q[4+w].reg_out), int'(tbl[t].ro_t4));
      check_val($sformatf("vec%0d_alu_op_t4", t), int'(obs_q[4+w].alu_op), int'(tbl[t].alu));
      check_val($sformatf("vec%0d_reg_in_last", t), int'(obs_q[obs_q.size()-1].reg_in),
                int'(tbl[t].ri_last));
      check_val($sformatf("vec%0d_illegal", t), int'(obs_q[obs_q.size()-1].illegal),
                int'(tbl[t].ill));
      if (tbl[t].ill) check_sticky(tbl[t].sel8, 3);
    end

    // Clear in T4 of an ADD, then restart from T0
    do_clear();
    run_instr(32'h1A920000, 0, 1'b0, 99, 1'b1, 4);
    run_instr(32'h1A920000, 0, 1'b0, 99, 1'b1, -1);

    // run dropped in T4: instruction completes, then IDLE
    do_clear();
    run_instr(32'h1A920000, 0, 1'b0, 4, 1'b0, -1);
    check_val("drop_run_done", int'(obs_q[5].done), 1);

    // Randomised back-to-back streams on both register counts
    for (int pass = 0; pass < 2; pass++) begin
      sel8  = (pass == 1);
      nregs = sel8 ? 8 : 16;
      do_clear();
      for (int k = 0; k < 150; k++) begin
        if ($urandom_range(0, 19) == 0) opc = int'($urandom_range(0, 31));
        else                            opc = legal_ops[$urandom_range(0, 9)];
        if (sel8 && $urandom_range(0, 9) != 0) begin
          ra = int'($urandom_range(0, 7));
          rb = int'($urandom_range(0, 7));
          rc = int'($urandom_range(0, 7));
        end else begin
          ra = int'($urandom_range(0, 15));
          rb = int'($urandom_range(0, 15));
          rc = int'($urandom_range(0, 15));
        end
        ir = mk_ir(opc, ra, rb, rc);
        w  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
        run_instr(ir, w, sel8, int'($urandom_range(0, 10)),
                  1'($urandom_range(0, 7) != 0), -1);
        if (exp_q[exp_q.size()-1].illegal) begin
          check_sticky(sel8, 1);
          do_clear();
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Hardwired control sequencer for the bus-based datapath.
- Generates the fetch (T0–T2) and execute (T3–T5/T6) control strobes that are currently hand-driven per test. The strobes cover register-register ALU instructions, including the HI/LO writeback for MUL/DIV.
- Register count, data width and memory latency are generalised: a variable-latency memory handshake stretches T1.
- Sits between the IR output and all datapath enable inputs.

Parameters:
- NUM_REGS, 16, number of general registers driven by the one-hot reg_in/reg_out vectors (2..16).
- DATA_W, 32, IR width.
- OPC_W, 5, opcode/ALU select width.

Ports:
- Clock  in  1  system clock, rising edge.
- Clear  in  1  asynchronous, active-high reset.
- run  in  1  level; while high, instructions execute back-to-back.
- ir_in  in  DATA_W  current IR contents. Fields: opcode [31:27], ra [26:23], rb [22:19], rc [18:15].
- mem_ready  in  1  memory read data valid this cycle.
- PCout, PCin, IncPC, MARin  out  1 each  PC/MAR strobes.
- Read, MDRin, MDRout, IRin  out  1 each  memory/IR strobes.
- Yin, ZLowIn, ZHighIn, Zlowout, ZHighout, HIin, LOin  out  1 each  ALU path strobes.
- alu_op  out  OPC_W  ALU function select.
- reg_in  out  NUM_REGS  one-hot register write enables.
- reg_out  out  NUM_REGS  one-hot register bus drivers.
- busy  out  1  high in any state except IDLE/ILLEGAL.
- done  out  1  one-cycle pulse in an instruction's final T state.
- illegal  out  1  sticky, set on undecodable instruction.

Behaviour:
- Moore machine. All outputs decode combinationally from the registered state and the latched fields only, never from ir_in directly after T2.
- Clear asynchronously forces IDLE, clears illegal and the latched fields, and drives every output to 0, including mid-instruction. No partial strobe survives Clear.
- States: IDLE, T0, T1, T2, T3, T4, T5, T6, ILLEGAL.
- IDLE: all outputs 0. Go to T0 when run=1.
- T0: PCout, MARin, IncPC, ZLowIn.
- T1: Zlowout, PCin, Read, MDRin.
  - If mem_ready=0, stay in T1 with all T1 strobes held.
  - PCin is asserted only in the first T1 cycle (guards against double PC load).
  - Leave to T2 on mem_ready=1.
- T2: MDRout, IRin. IR loads at the end of this cycle.
- T3:
  - Latch opcode/ra/rb/rc from ir_in on entry, i.e. at the T2→T3 edge.
  - Assert reg_out[rb] and Yin.
  - Decode legal opcodes: ADD 00011, SUB 00100, AND 00101, OR 00110, SHR 00111, SHL 01000, ROR 01001, ROL 01010, MUL 01111, DIV 10000.
  - Illegal opcode, or any index ≥ NUM_REGS: go to ILLEGAL at the next edge. No T3 strobes are asserted in that cycle; reg_out stays 0.
- T4: reg_out[rc], ZLowIn, alu_op = latched opcode. ZHighIn is also asserted for MUL/DIV. alu_op = 0 in every other state.
- T5:
  - Non-MUL/DIV: Zlowout, reg_in[ra], done.
  - MUL/DIV: Zlowout, LOin.
- T6 (MUL/DIV only): ZHighout, HIin, done.
- After the done state: T0 if run=1, else IDLE. run going low mid-instruction does not abort; the instruction completes.
- ILLEGAL: illegal=1, all other outputs 0. Exit only via Clear.
- Latency with mem_ready tied high: 6 cycles per ALU instruction, 7 per MUL/DIV. Each cycle of mem_ready=0 in T1 adds 1.
- Invariants: at most one bus driver (PCout, Zlowout, ZHighout, MDRout, any reg_out bit) asserted in any cycle. reg_in and reg_out are each one-hot or zero.

Decomposition:
- Shared package cpu_ctrl_pkg holds:
  - state enum/localparams;
  - opcode localparams (shared with the ALU);
  - IR field bit positions;
  - the is_legal_op and is_hilo_op functions.
- One sub-module, reg_sel_decoder: 4-bit index + enable → NUM_REGS one-hot, with an out-of-range flag. Instantiated twice, once for reg_in and once for reg_out.

Test Plan:
- Clear mid-T4 of an ADD → every output 0 within the same cycle; busy=0; restart from T0 when run=1.
- run=1, mem_ready=1, ir_in=0x1A920000 (ADD R5,R2,R4):
  - T3: reg_out=0x0004, Yin.
  - T4: reg_out=0x0010, alu_op=00011, ZLowIn.
  - T5: Zlowout, reg_in=0x0020, done.
  - 6 cycles T0→T5.
- ir_in=0x781B0000 (MUL rb=R3, rc=R6):
  - T4: ZLowIn and ZHighIn.
  - T5: LOin.
  - T6: HIin and done.
  - reg_in stays 0 throughout; 7 cycles.
- mem_ready low for 3 cycles in T1 → T1 held 4 cycles; PCin high only in the first; Read/MDRin high all 4; done 3 cycles later than nominal.
- Opcode 11111 (ir_in=0xF8000000) → ILLEGAL after T3; illegal=1 sticky; all strobes 0 until Clear.
- NUM_REGS=8, ADD with rc=9 → ILLEGAL. run dropped during T4 of a legal ADD → the instruction completes with done, then IDLE.
